// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with word-organised data memory,
// byte/half/word loads and stores, and the MEM/WB pipeline register.
// Ports: Clock, Reset_n (async, active low); RegWriteM, MemtoRegM,
//   MemWriteM, MemSizeM, MemUnsignedM, ALUResultM, WriteDataM,
//   WriteRegM, StallM, FlushM in; RegWriteW, MemtoRegW, ALUResultW,
//   ReadDataW, WriteRegW out; MisalignM out only with the optional
//   MEM_ALIGN_CHECK_EN macro (misaligned access detection).
module mem_stage #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        RegWriteM,
   input  logic        MemtoRegM,
   input  logic        MemWriteM,
   input  logic [1:0]  MemSizeM,
   input  logic        MemUnsignedM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  WriteRegM,
   input  logic        StallM,
   input  logic        FlushM,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [4:0]  WriteRegW
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        MisalignM
`endif
);

   logic [31:0]   r_mem [DEPTH];

   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic [4:0]    w_sh;
   logic [31:0]   w_word;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_ld;
   logic [3:0]    w_be;
   logic [31:0]   w_wd;
   logic          w_mis;
   logic          w_we;
   logic          w_unused;

   // Upper address bits are deliberately dropped: addresses alias
   // modulo DEPTH*4.
   assign w_idx    = ALUResultM[AW+1:2];
   assign w_lane   = ALUResultM[1:0];
   assign w_sh     = {w_lane, 3'b000};
   assign w_unused = ^ALUResultM[31:AW+2];

   assign w_word = r_mem[w_idx];
   assign w_byte = w_word[w_sh +: 8];
   assign w_half = ALUResultM[1] ? w_word[31:16] : w_word[15:0];

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      w_mis = 1'b0;
      unique case (MemSizeM)
         2'b00:   w_mis = 1'b0;
         2'b01:   w_mis = ALUResultM[0];
         default: w_mis = |ALUResultM[1:0];
      endcase
      w_mis = w_mis & (MemWriteM | MemtoRegM);
   end
   assign MisalignM = w_mis;
`else
   assign w_mis = 1'b0;
`endif

   // Load path: lane select, then sign or zero extension.
   always_comb begin
      w_ld = w_word;
      unique case (MemSizeM)
         2'b00: begin
            if (MemUnsignedM)
               w_ld = {24'b0, w_byte};
            else
               w_ld = {{24{w_byte[7]}}, w_byte};
         end
         2'b01: begin
            if (MemUnsignedM)
               w_ld = {16'b0, w_half};
            else
               w_ld = {{16{w_half[15]}}, w_half};
         end
         default: w_ld = w_word;
      endcase
   end

   // Store path: replicate sub-word data across lanes so the lane
   // enables alone decide which bytes change.
   always_comb begin
      w_be = 4'b1111;
      w_wd = WriteDataM;
      unique case (MemSizeM)
         2'b00: begin
            w_be = 4'b0001 << w_lane;
            w_wd = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            w_be = ALUResultM[1] ? 4'b1100 : 4'b0011;
            w_wd = {2{WriteDataM[15:0]}};
         end
         default: begin
            w_be = 4'b1111;
            w_wd = WriteDataM;
         end
      endcase
   end

   assign w_we = MemWriteM & ~StallM & ~FlushM & ~w_mis;

   // Memory contents survive reset; only the store is blocked
   // while reset is asserted.
   always_ff @(posedge Clock) begin
      if (Reset_n && w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b])
               r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
         end
      end
   end

   // MEM/WB register: flush beats stall.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         RegWriteW  <= 1'b0;
         MemtoRegW  <= 1'b0;
         ALUResultW <= 32'b0;
         ReadDataW  <= 32'b0;
         WriteRegW  <= 5'b0;
      end else if (FlushM) begin
         RegWriteW  <= 1'b0;
         MemtoRegW  <= 1'b0;
         ALUResultW <= 32'b0;
         ReadDataW  <= 32'b0;
         WriteRegW  <= 5'b0;
      end else if (!StallM) begin
         // A misaligned load must not reach the register file.
         RegWriteW  <= RegWriteM & ~(w_mis & MemtoRegM);
         MemtoRegW  <= MemtoRegM;
         ALUResultW <= ALUResultM;
         ReadDataW  <= w_ld;
         WriteRegW  <= WriteRegM;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven bench for mem_stage with a scoreboard
// queue of expected MEM/WB values.
module tb_mem_stage;

   logic        Clock;
   logic        Reset_n;
   logic        RegWriteM;
   logic        MemtoRegM;
   logic        MemWriteM;
   logic [1:0]  MemSizeM;
   logic        MemUnsignedM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [4:0]  WriteRegM;
   logic        StallM;
   logic        FlushM;
   logic        RegWriteW;
   logic        MemtoRegW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [4:0]  WriteRegW;
`ifdef MEM_ALIGN_CHECK_EN
   logic        MisalignM;
`endif

   mem_stage #(.DEPTH(256), .AW(8)) dut (
      .Clock(Clock),
      .Reset_n(Reset_n),
      .RegWriteM(RegWriteM),
      .MemtoRegM(MemtoRegM),
      .MemWriteM(MemWriteM),
      .MemSizeM(MemSizeM),
      .MemUnsignedM(MemUnsignedM),
      .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM),
      .WriteRegM(WriteRegM),
      .StallM(StallM),
      .FlushM(FlushM),
      .RegWriteW(RegWriteW),
      .MemtoRegW(MemtoRegW),
      .ALUResultW(ALUResultW),
      .ReadDataW(ReadDataW),
      .WriteRegW(WriteRegW)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .MisalignM(MisalignM)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        rw;
      logic        m2r;
      logic [4:0]  wreg;
      logic        st;
      logic        fl;
      logic        chk;
      logic [31:0] rd;
      logic        erw;
      logic        mis;
   } vec_t;

   typedef struct {
      logic        rw;
      logic        m2r;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [4:0]  wreg;
      logic        chk;
   } out_t;

   vec_t tbl[$];
   out_t sb[$];
   out_t last;
   int   n_err;
   int   n_chk;

   function automatic vec_t st_v(logic [1:0] sz, logic [31:0] a,
                                 logic [31:0] wd, logic c,
                                 logic [31:0] rd);
      vec_t v;
      v.we = 1; v.sz = sz; v.uns = 0; v.addr = a; v.wd = wd;
      v.rw = 0; v.m2r = 0; v.wreg = 0; v.st = 0; v.fl = 0;
      v.chk = c; v.rd = rd; v.erw = 0; v.mis = 0;
      return v;
   endfunction

   function automatic vec_t ld_v(logic [1:0] sz, logic u,
                                 logic [31:0] a, logic [4:0] r,
                                 logic [31:0] rd);
      vec_t v;
      v.we = 0; v.sz = sz; v.uns = u; v.addr = a; v.wd = 0;
      v.rw = 1; v.m2r = 1; v.wreg = r; v.st = 0; v.fl = 0;
      v.chk = 1; v.rd = rd; v.erw = 1; v.mis = 0;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cmp_out(string tag);
      out_t e;
      if (sb.size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: scoreboard empty", tag);
         return;
      end
      e = sb.pop_front();
      chk({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(e.rw));
      chk({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'(e.m2r));
      chk({tag, ".ALUResultW"}, ALUResultW, e.alu);
      chk({tag, ".WriteRegW"}, 32'(WriteRegW), 32'(e.wreg));
      if (e.chk)
         chk({tag, ".ReadDataW"}, ReadDataW, e.rd);
   endtask

   task automatic run(vec_t v, int id);
      out_t e;
      @(negedge Clock);
      MemWriteM    = v.we;
      MemSizeM     = v.sz;
      MemUnsignedM = v.uns;
      ALUResultM   = v.addr;
      WriteDataM   = v.wd;
      RegWriteM    = v.rw;
      MemtoRegM    = v.m2r;
      WriteRegM    = v.wreg;
      StallM       = v.st;
      FlushM       = v.fl;
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      chk($sformatf("v%0d.MisalignM", id), 32'(MisalignM), 32'(v.mis));
`endif
      if (v.fl) begin
         e = '{rw: 0, m2r: 0, alu: 0, rd: 0, wreg: 0, chk: 1};
      end else if (v.st) begin
         e = last;
      end else begin
         e.rw = v.erw; e.m2r = v.m2r; e.alu = v.addr;
         e.rd = v.rd; e.wreg = v.wreg; e.chk = v.chk;
      end
      last = e;
      sb.push_back(e);
      @(posedge Clock);
      #1;
      cmp_out($sformatf("v%0d", id));
   endtask

   logic [31:0] w11;
   vec_t        v;

   initial begin
      n_err = 0;
      n_chk = 0;
      last  = '{rw: 0, m2r: 0, alu: 0, rd: 0, wreg: 0, chk: 1};
      Reset_n = 0;
      RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0; MemSizeM = 2;
      MemUnsignedM = 0; ALUResultM = 32'h44; WriteDataM = 0;
      WriteRegM = 5'd3; StallM = 0; FlushM = 0;
      #1;
      chk("rst.RegWriteW", 32'(RegWriteW), 0);
      chk("rst.MemtoRegW", 32'(MemtoRegW), 0);
      chk("rst.ALUResultW", ALUResultW, 0);
      chk("rst.ReadDataW", ReadDataW, 0);
      chk("rst.WriteRegW", 32'(WriteRegW), 0);
      @(negedge Clock);
      Reset_n = 1;

`ifdef MEM_ALIGN_CHECK_EN
      w11 = 32'h80223344;
`else
      w11 = 32'h01020304;
`endif

      tbl.push_back(st_v(2, 32'h10, 32'hDEADBEEF, 0, 0));
      tbl.push_back(ld_v(2, 0, 32'h10, 5, 32'hDEADBEEF));
      tbl.push_back(st_v(2, 32'h10, 32'h11223344, 1, 32'hDEADBEEF));
      tbl.push_back(st_v(0, 32'h13, 32'h12345680, 1, 32'h00000011));
      tbl.push_back(ld_v(0, 0, 32'h13, 7, 32'hFFFFFF80));
      tbl.push_back(ld_v(0, 1, 32'h13, 7, 32'h00000080));
      tbl.push_back(ld_v(2, 0, 32'h10, 8, 32'h80223344));
      tbl.push_back(st_v(2, 32'h20, 32'h00000000, 0, 0));
      tbl.push_back(st_v(1, 32'h22, 32'h5A5AA5A5, 1, 0));
      tbl.push_back(ld_v(1, 0, 32'h22, 10, 32'hFFFFA5A5));
      tbl.push_back(ld_v(2, 0, 32'h20, 11, 32'hA5A50000));
      tbl.push_back(ld_v(1, 1, 32'h20, 12, 32'h00000000));
      tbl.push_back(st_v(2, 32'h400, 32'hCAFEF00D, 0, 0));
      tbl.push_back(ld_v(2, 0, 32'h0, 13, 32'hCAFEF00D));
      tbl.push_back(ld_v(2, 0, 32'h10, 9, 32'h80223344));
      v = st_v(2, 32'h10, 32'hFFFFFFFF, 0, 0);
      v.st = 1;
      tbl.push_back(v);
      tbl.push_back(v);
      tbl.push_back(ld_v(2, 0, 32'h10, 14, 32'h80223344));
      v = st_v(2, 32'h10, 32'h00000000, 0, 0);
      v.st = 1; v.fl = 1; v.rw = 1; v.wreg = 9;
      tbl.push_back(v);
      tbl.push_back(ld_v(2, 0, 32'h10, 15, 32'h80223344));
      tbl.push_back(st_v(0, 32'h21, 32'h000000AB, 1, 0));
      tbl.push_back(ld_v(2, 0, 32'h20, 16, 32'hA5A5AB00));
      tbl.push_back(ld_v(0, 1, 32'h21, 17, 32'h000000AB));
      tbl.push_back(ld_v(0, 0, 32'h21, 18, 32'hFFFFFFAB));
      v = st_v(2, 32'h11, 32'h01020304, 1, 32'h80223344);
      v.mis = 1;
      tbl.push_back(v);
      tbl.push_back(ld_v(2, 0, 32'h10, 19, w11));
      v = ld_v(1, 0, 32'h21, 20, 32'hFFFFAB00);
      v.mis = 1;
`ifdef MEM_ALIGN_CHECK_EN
      v.erw = 0;
`endif
      tbl.push_back(v);

      foreach (tbl[i]) run(tbl[i], i);

      run(ld_v(2, 0, 32'h10, 3, w11), 100);
      @(negedge Clock);
      StallM = 1; MemWriteM = 1; MemSizeM = 2;
      ALUResultM = 32'h20; WriteDataM = 32'h0;
      #2;
      Reset_n = 0;
      #1;
      chk("rstmid.RegWriteW", 32'(RegWriteW), 0);
      chk("rstmid.ALUResultW", ALUResultW, 0);
      chk("rstmid.ReadDataW", ReadDataW, 0);
      chk("rstmid.WriteRegW", 32'(WriteRegW), 0);
      chk("rstmid.MemtoRegW", 32'(MemtoRegW), 0);
      StallM = 0;
      @(posedge Clock);
      #1;
      chk("rsthold.RegWriteW", 32'(RegWriteW), 0);
      @(negedge Clock);
      Reset_n = 1;
      MemWriteM = 0;
      last = '{rw: 0, m2r: 0, alu: 0, rd: 0, wreg: 0, chk: 1};
      run(ld_v(2, 0, 32'h20, 21, 32'hA5A5AB00), 101);
      run(ld_v(2, 0, 32'h10, 22, w11), 102);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
